// File: rtl/inference_sequencer_pkg.sv
// Shared types and default widths for the inference sequencer and the core it drives.
package inference_sequencer_pkg;

  localparam int IN_W_DEF  = 48;
  localparam int OUT_W_DEF = 16;
  localparam int TAG_W_DEF = 8;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_CRST,
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_HOLD
  } seq_state_e;

endpackage

// File: rtl/inference_sequencer.sv
// Runs one ap_ctrl_hs inference core a sample at a time: start/ready handshake, result
// capture, valid/ready output with the sample tag, and a watchdog that resets a hung core.
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int TIMEOUT_CYC = 4096,
  parameter int RST_CYC     = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_data,
  input  logic [TAG_W-1:0] s_tag,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             core_rst,
  output logic             core_start,
  output logic [IN_W-1:0]  core_in,
  output logic             core_in_vld,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic [OUT_W-1:0] core_out,
  input  logic             core_out_vld,
  output logic [OUT_W-1:0] m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] infer_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RC_W = $clog2(RST_CYC + 1);

  seq_state_e       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [IN_W-1:0]  core_in_q, core_in_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] infer_q, infer_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             active;
  logic             abort;

  assign active = (state_q == ST_START) || (state_q == ST_WAIT);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    wd_d      = wd_q;
    core_in_d = core_in_q;
    tag_d     = tag_q;
    m_data_d  = m_data_q;
    seen_d    = seen_q;
    err_d     = err_q;
    infer_d   = infer_q;
    tmo_d     = tmo_q;
    abort     = 1'b0;

    case (state_q)
      ST_CRST: begin
        if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
          rst_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_IDLE: begin
        if (s_valid) begin
          core_in_d = s_data;
          tag_d     = s_tag;
          seen_d    = 1'b0;
          wd_d      = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (core_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          if (seen_q || core_out_vld) begin
            if (infer_q != '1) infer_d = infer_q + CNT_W'(1);
            state_d = ST_HOLD;
          end else begin
            abort = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_CRST;
    endcase

    // Only the first result of an inference is kept; repeats from the core are ignored.
    if (active && core_out_vld && !seen_q) begin
      m_data_d = core_out;
      seen_d   = 1'b1;
    end

    if (active) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_q == WD_W'(TIMEOUT_CYC - 1) && state_d != ST_HOLD) abort = 1'b1;
    end

    if (abort) begin
      err_d     = 1'b1;
      if (tmo_q != '1) tmo_d = tmo_q + CNT_W'(1);
      rst_cnt_d = '0;
      state_d   = ST_CRST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CRST;
      rst_cnt_q <= '0;
      wd_q      <= '0;
      core_in_q <= '0;
      tag_q     <= '0;
      m_data_q  <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      infer_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      wd_q      <= wd_d;
      core_in_q <= core_in_d;
      tag_q     <= tag_d;
      m_data_q  <= m_data_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      infer_q   <= infer_d;
      tmo_q     <= tmo_d;
    end
  end

  assign s_ready     = (state_q == ST_IDLE);
  assign core_rst    = (state_q == ST_CRST);
  assign core_start  = (state_q == ST_START);
  assign core_in_vld = (state_q == ST_START);
  assign core_in     = core_in_q;
  assign m_valid     = (state_q == ST_HOLD);
  assign m_data      = m_data_q;
  assign m_tag       = tag_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;
  assign infer_cnt   = infer_q;
  assign timeout_cnt = tmo_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: behavioural HLS core model, result scoreboard, directed and random samples.
module tb_inference_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] s_data;
  logic [7:0]  s_tag;
  logic        s_valid;
  logic        s_ready;
  logic        core_rst;
  logic        core_start;
  logic [47:0] core_in;
  logic        core_in_vld;
  logic        core_ready   = 1'b0;
  logic        core_done    = 1'b0;
  logic [15:0] core_out     = 16'h0;
  logic        core_out_vld = 1'b0;
  logic [15:0] m_data;
  logic [7:0]  m_tag;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        timeout_err;
  logic [31:0] infer_cnt;
  logic [31:0] timeout_cnt;

  logic mr_mode  = 1'b0;
  logic mr_fixed = 1'b1;
  logic mr_rand  = 1'b1;
  assign m_ready = mr_mode ? mr_rand : mr_fixed;

  int cfg_rdy  = 0;
  int cfg_lat  = 10;
  int cfg_off  = 5;
  bit cfg_hung = 1'b0;
  bit cfg_dup  = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  inference_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_tag(s_tag), .s_valid(s_valid), .s_ready(s_ready),
    .core_rst(core_rst), .core_start(core_start), .core_in(core_in), .core_in_vld(core_in_vld),
    .core_ready(core_ready), .core_done(core_done), .core_out(core_out), .core_out_vld(core_out_vld),
    .m_data(m_data), .m_tag(m_tag), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .timeout_err(timeout_err), .infer_cnt(infer_cnt), .timeout_cnt(timeout_cnt)
  );

  // What the core computes for a feature word.
  function automatic logic [15:0] result_of(input logic [47:0] d);
    logic [15:0] s;
    s = d[47:32] + (d[31:16] << 1) + d[15:0];
    return s ^ 16'hA5A5;
  endfunction

  // Behavioural core: ap_ready after cfg_rdy start cycles, result at offset, done at latency.
  int ph = 0, wn = 0, cnt = 0, l_lat = 1, l_off = 0;
  bit l_hung = 1'b0, l_dup = 1'b0;
  logic [15:0] l_res = 16'h0;
  always begin
    @(posedge clk);
    #1;
    if (core_rst) begin
      ph = 0; wn = 0;
      core_ready = 1'b0; core_done = 1'b0; core_out_vld = 1'b0; core_out = 16'h0;
    end else begin
      case (ph)
        0: begin
          core_done = 1'b0; core_out_vld = 1'b0; core_ready = 1'b0; core_out = ~l_res;
          if (core_start) begin
            if (wn >= cfg_rdy) begin
              core_ready = 1'b1; wn = 0; cnt = 0; ph = 1;
              l_res = result_of(core_in);
              l_lat = cfg_lat; l_off = cfg_off; l_hung = cfg_hung; l_dup = cfg_dup;
              core_out = ~l_res;
              if (l_off == 0) begin core_out_vld = 1'b1; core_out = l_res; end
            end else begin
              wn++;
            end
          end
        end
        1: begin
          core_ready = 1'b0; core_done = 1'b0; core_out_vld = 1'b0; core_out = ~l_res;
          cnt++;
          if (cnt == l_off) begin core_out_vld = 1'b1; core_out = l_res; end
          else if (l_dup && cnt == l_off + 1) core_out_vld = 1'b1;
          if (!l_hung && cnt >= l_lat) begin core_done = 1'b1; ph = 2; end
        end
        default: begin
          core_done = 1'b0; core_out_vld = l_dup; core_out = ~l_res; ph = 0;
        end
      endcase
    end
  end

  always begin
    @(posedge clk);
    #1;
    mr_rand = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got still running, expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle output checker: ordering/content against the scoreboard, stability under stall.
  task automatic monitor();
    logic        hv;
    logic [15:0] pd;
    logic [7:0]  pt;
    logic [23:0] e;
    hv = 1'b0; pd = '0; pt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 1'b0;
      end else begin
        if (hv) begin
          check("hold_valid", 64'(m_valid), 1);
          check("hold_data", 64'(m_data), 64'(pd));
          check("hold_tag", 64'(m_tag), 64'(pt));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("result_pending", 64'(exp_q.size() > 0), 1);
          end else begin
            e = exp_q.pop_front();
            check("m_data", 64'(m_data), 64'(e[23:8]));
            check("m_tag", 64'(m_tag), 64'(e[7:0]));
          end
        end
        hv = m_valid && !m_ready;
        pd = m_data;
        pt = m_tag;
      end
    end
  endtask

  task automatic send(input logic [47:0] d, input logic [7:0] t);
    bit ok;
    ok = 1'b0;
    s_data = d; s_tag = t; s_valid = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        exp_q.push_back({result_of(d), t});
      end
      tick();
      if (ok) break;
    end
    s_valid = 1'b0;
    check("send_accepted", 64'(ok), 1);
  endtask

  task automatic wait_mvalid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 500) begin tick(); n++; end
    check(name, 64'(m_valid), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!s_ready && n < 500) begin tick(); n++; end
    check("wait_idle", 64'(s_ready), 1);
  endtask

  initial begin
    int n;
    logic [47:0] d;
    logic [15:0] held_data;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_tag = '0;
    fork monitor(); join_none
    repeat (3) tick();

    // Reset: core_rst for exactly 4 cycles after release, then idle with outputs clear.
    check("rst_core_rst_low", 64'(core_rst), 1);
    rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (!core_rst) break;
    end
    check("rst_core_rst_cycles", 64'(n), 4);
    check("rst_s_ready", 64'(s_ready), 1);
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_m_data", 64'(m_data), 0);
    check("rst_core_start", 64'(core_start), 0);
    check("rst_infer_cnt", 64'(infer_cnt), 0);
    check("rst_timeout_cnt", 64'(timeout_cnt), 0);
    check("rst_timeout_err", 64'(timeout_err), 0);

    // Single sample with a literal expected result.
    mr_fixed = 1'b1; cfg_lat = 10; cfg_off = 5; cfg_rdy = 0;
    send(48'h0001_0002_0003, 8'h5A);
    @(negedge clk);
    check("single_core_start", 64'(core_start), 1);
    check("single_core_in_vld", 64'(core_in_vld), 1);
    check("single_core_in", 64'(core_in), 64'h0001_0002_0003);
    wait_mvalid("single_m_valid");
    check("single_m_data_lit", 64'(m_data), 64'hA5AD);
    check("single_m_tag_lit", 64'(m_tag), 64'h5A);
    check("single_infer_cnt", 64'(infer_cnt), 1);

    // Backpressure for 50 cycles.
    wait_idle();
    mr_fixed = 1'b0; cfg_off = 10;
    send(48'h1234_5678_9ABC, 8'h33);
    wait_mvalid("bp_m_valid");
    held_data = m_data;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_s_ready", 64'(s_ready), 0);
      check("bp_timeout_err", 64'(timeout_err), 0);
    end
    check("bp_data_held", 64'(m_data), 64'(held_data));
    mr_fixed = 1'b1;
    tick();
    check("bp_release_m_valid", 64'(m_valid), 0);
    check("bp_release_s_ready", 64'(s_ready), 1);

    // ap_ready held low for 7 start cycles.
    cfg_rdy = 7; cfg_off = 3;
    d = 48'hCAFE_0F0F_BEEF;
    send(d, 8'h44);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("dly_core_start", 64'(core_start), 1);
      check("dly_core_in", 64'(core_in), 64'(d));
      check("dly_core_ready", 64'(core_ready), 0);
      tick();
    end
    @(negedge clk);
    check("dly_core_ready_rise", 64'(core_ready), 1);
    wait_mvalid("dly_m_valid");
    check("dly_infer_cnt", 64'(infer_cnt), 3);

    // Hung core: watchdog abort after TIMEOUT_CYC cycles.
    wait_idle();
    cfg_rdy = 0; cfg_hung = 1'b1;
    send(48'hDEAD_0000_0001, 8'h77);
    n = 0;
    while (!timeout_err && n < 5000) begin tick(); n++; end
    check("hung_timeout_cycles", 64'(n), 4096);
    void'(exp_q.pop_back());
    check("hung_timeout_cnt", 64'(timeout_cnt), 1);
    check("hung_infer_cnt", 64'(infer_cnt), 3);
    n = 0;
    while (core_rst && n < 20) begin n++; tick(); end
    check("hung_core_rst_cycles", 64'(n), 4);
    cfg_hung = 1'b0;
    send(48'h0000_1111_2222, 8'h78);
    wait_mvalid("hung_next_m_valid");
    check("hung_next_infer_cnt", 64'(infer_cnt), 4);
    check("hung_err_sticky", 64'(timeout_err), 1);

    // Reset during WAIT drops the sample.
    wait_idle();
    cfg_lat = 30; cfg_off = 20;
    send(48'h9999_8888_7777, 8'h99);
    repeat (5) tick();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle();
    check("midrst_infer_cnt", 64'(infer_cnt), 0);
    check("midrst_timeout_err", 64'(timeout_err), 0);

    // 100 back-to-back random samples with random downstream ready.
    mr_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wait_idle();
      cfg_lat = $urandom_range(1, 8);
      cfg_off = $urandom_range(0, cfg_lat);
      cfg_rdy = $urandom_range(0, 3);
      cfg_dup = 1'($urandom_range(0, 1));
      d = {16'($urandom), 16'($urandom), 16'($urandom)};
      send(d, 8'(k));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    mr_mode = 1'b0; mr_fixed = 1'b1;
    check("rand_all_results", 64'(exp_q.size()), 0);
    tick();
    check("rand_infer_cnt", 64'(infer_cnt), 100);
    check("rand_timeout_cnt", 64'(timeout_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
